sep_gauss_filter_param: RTL
===========================

Name: sep_gauss_filter_param

Overview:
- Parametrised, mode-selectable successor to the fixed 5x5 separable Gaussian stage in the vision pipeline.
- Takes a raster pixel stream framed by start-of-frame.
- Applies a vertical-then-horizontal separable blur: 5x5 [1 4 6 4 1]/16, 3x3 [1 2 1]/4, or bypass.
- Emits a centre-aligned stream with exactly IMG_WIDTH*IMG_HEIGHT outputs per frame. An internal flush phase drains the last rows, so downstream never loses the frame tail.

Parameters:
- DATA_WIDTH, 8, pixel bit width.
- IMG_WIDTH, 640, pixels per row; must be at least 5.
- IMG_HEIGHT, 480, rows per frame; must be at least 5.
- BORDER_MODE, 0, 0 = border outputs are zero; 1 = border outputs are the unfiltered centre pixel.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_pixel  in  DATA_WIDTH  input pixel.
- i_valid  in  1  input pixel qualifier.
- i_sof  in  1  first pixel of frame; meaningful only with i_valid.
- i_mode  in  2  00 bypass, 01 gauss5, 10 gauss3, 11 treated as bypass; sampled on accepted i_sof.
- i_ready  out  1  block accepts input; low only during FLUSH.
- o_pixel  out  DATA_WIDTH  filtered pixel.
- o_valid  out  1  output qualifier.
- o_sof  out  1  with o_valid, first output of frame.
- o_eof  out  1  with o_valid, last output of frame.

Behaviour:
- Reset (async, rst_n=0) forces:
  - o_pixel=0, o_valid=0, o_sof=0, o_eof=0, i_ready=1.
  - State IDLE; all counters 0; mode register 00.
  - Line buffers need not clear; garbage never reaches a non-border output.
- Accept = i_valid & i_ready. An "advance" is an accept in FILL/RUN, or any FLUSH cycle. Line buffers, window and counters shift only on advance.
- FSM:
  - IDLE: accepts without i_sof are dropped. An accept with i_sof latches i_mode, loads that pixel as index 0, and goes to FILL.
  - FILL: advances on accept, emits no output, for the first 2*IMG_WIDTH+2 advances (the sof pixel counts). Then goes to RUN.
  - RUN: each advance emits one output. After the pixel with index IMG_WIDTH*IMG_HEIGHT-1 is accepted, goes to FLUSH.
  - FLUSH: i_ready=0. Performs one advance per clock feeding zero pixels, 2*IMG_WIDTH+2 times, then goes to IDLE.
  - Any accepted i_sof in FILL or RUN aborts the frame: pending outputs are discarded and the block restarts as the IDLE-with-sof transition. No o_eof is issued for the aborted frame.
- Alignment: the output emitted at advance n corresponds to centre pixel index n-(2*IMG_WIDTH+2), with row/col counters tracking the centre. Outputs are registered, so o_valid follows the advance by 1 clock. Unstalled latency is 2*IMG_WIDTH+3 clocks.
- o_sof marks centre index 0. o_eof marks centre index IMG_WIDTH*IMG_HEIGHT-1, the last FLUSH advance.
- Arithmetic, gauss5:
  - Vertical: v = (r0 + 4r1 + 6r2 + 4r3 + r4 + 8) >> 4, computed in DATA_WIDTH+4 bits. The result fits DATA_WIDTH.
  - Horizontal: the same kernel over 5 successive v values, same rounding.
- Arithmetic, gauss3: uses the centre 3 rows/cols, (a + 2b + c + 2) >> 2, in DATA_WIDTH+2 bits.
- Rounding is round-half-up throughout; no saturation is needed.
- Bypass output is the centre pixel at the same latency.
- Border region:
  - gauss5: rows 0,1,H-2,H-1 and cols 0,1,W-2,W-1.
  - gauss3: row/col 0 and H-1 / W-1.
  - bypass: no border.
  - Border outputs follow BORDER_MODE. Zeros injected during flush and row wrap-around only ever fall under border outputs.
- Mode changes mid-frame are ignored until the next accepted sof.

Test Plan:
- W=9, H=6, gauss5, BORDER_MODE=0, constant 100, i_valid always high:
  - Exactly 54 outputs; interior (rows 2-3, cols 2-6) = 100; all else 0.
  - o_sof on output 1, o_eof on output 54; first o_valid 21 clocks after the sof accept.
  - i_ready low for 20 clocks after the last input.
- Same frame, gauss5, single 255 at (2,4), zeros elsewhere:
  - (2,4)=36, (2,3)=24, (2,5)=24, (3,4)=24.
  - Other interior pixels follow the same two-stage rounding; border = 0.
- gauss3, BORDER_MODE=1, constant 100 with (0,0)=7:
  - Interior rows 1-4, cols 1-7: constant 100 except (1,1) = 100 - round effects computed by the bench model.
  - (0,0) outputs 7.
- Random i_valid gaps (about 50%), random pixels, gauss5:
  - Outputs bit-match a golden model.
  - Output count is 54; no output while i_valid is low in RUN.
- Mode and abort:
  - i_mode toggled mid-frame: no effect on that frame.
  - Second i_sof at pixel 30: no o_eof for the aborted frame; the next 54 outputs match the new frame.
- Reset and idle:
  - rst_n pulsed low mid-RUN, asynchronously: outputs 0 immediately, state IDLE.
  - Pixels without sof are then dropped; a new sof frame is correct.

Source files
------------

// File: rtl/sep_gauss_filter_param_if.sv
// Pixel stream bundle for the separable Gaussian stage: input side with
// ready back-pressure, plus the framed output side.
interface sep_gauss_filter_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_pixel;
    logic                  i_valid;
    logic                  i_sof;
    logic [1:0]            i_mode;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_pixel;
    logic                  o_valid;
    logic                  o_sof;
    logic                  o_eof;

    modport slave (
        input  i_pixel, i_valid, i_sof, i_mode,
        output i_ready, o_pixel, o_valid, o_sof, o_eof
    );

    modport master (
        output i_pixel, i_valid, i_sof, i_mode,
        input  i_ready, o_pixel, o_valid, o_sof, o_eof
    );
endinterface

// File: rtl/sep_gauss_filter_param.sv
// Separable Gaussian blur (5x5, 3x3 or bypass) over a raster stream.
// Four circular line buffers supply a 5-pixel column per advance; the vertical
// result is shifted through a short history for the horizontal pass. The
// newest pixel sits two rows and two columns past the centre, and a flush
// phase feeds zeros so the last rows still drain to the output.
module sep_gauss_filter_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int BORDER_MODE = 0
) (
    input logic                     clk,
    input logic                     rst_n,
    sep_gauss_filter_param_if.slave bus
);
    localparam int NPIX     = IMG_WIDTH * IMG_HEIGHT;
    localparam int FILL_CNT = 2 * IMG_WIDTH + 2;
    localparam int ADV_W    = $clog2(NPIX + FILL_CNT + 1);
    localparam int COL_W    = $clog2(IMG_WIDTH);
    localparam int ROW_W    = $clog2(IMG_HEIGHT);

    localparam logic [ADV_W-1:0] FILL_LAST  = ADV_W'(FILL_CNT - 1);
    localparam logic [ADV_W-1:0] RUN_LAST   = ADV_W'(NPIX - 1);
    localparam logic [ADV_W-1:0] FLUSH_LAST = ADV_W'(NPIX + FILL_CNT - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_TWO    = COL_W'(2);
    localparam logic [COL_W-1:0] COL_HI5    = COL_W'(IMG_WIDTH - 3);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_TWO    = ROW_W'(2);
    localparam logic [ROW_W-1:0] ROW_HI5    = ROW_W'(IMG_HEIGHT - 3);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_GAUSS5 = 2'b01,
        MODE_GAUSS3 = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    // [1 4 6 4 1]/16 with round-half-up; the sum never exceeds DATA_WIDTH+4 bits
    function automatic logic [DATA_WIDTH-1:0] kern5(
        input logic [DATA_WIDTH-1:0] a, b, c, d, e
    );
        logic [DATA_WIDTH+3:0] sum;
        sum = {4'b0, a} + {2'b0, b, 2'b0} + {2'b0, c, 2'b0} + {3'b0, c, 1'b0}
            + {2'b0, d, 2'b0} + {4'b0, e} + (DATA_WIDTH + 4)'(8);
        sum = sum >> 4;
        return sum[DATA_WIDTH-1:0];
    endfunction

    // [1 2 1]/4 with round-half-up; the sum never exceeds DATA_WIDTH+2 bits
    function automatic logic [DATA_WIDTH-1:0] kern3(
        input logic [DATA_WIDTH-1:0] a, b, c
    );
        logic [DATA_WIDTH+1:0] sum;
        sum = {2'b0, a} + {1'b0, b, 1'b0} + {2'b0, c} + (DATA_WIDTH + 2)'(2);
        sum = sum >> 2;
        return sum[DATA_WIDTH-1:0];
    endfunction

    state_t                r_state;
    state_t                w_nextState;
    mode_t                 r_mode;
    logic [ADV_W-1:0]      r_advCnt;
    logic [ADV_W-1:0]      w_adv;
    logic [COL_W-1:0]      r_wrCol;
    logic [COL_W-1:0]      w_wrCol;
    logic [ROW_W-1:0]      r_cRow;
    logic [COL_W-1:0]      r_cCol;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_restart;
    logic                  w_advance;
    logic                  w_emit;

    logic [DATA_WIDTH-1:0] r_lb [0:3][0:IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] r_h5 [0:3];
    logic [DATA_WIDTH-1:0] r_h3 [0:2];
    logic [DATA_WIDTH-1:0] r_ctr [0:1];
    logic [DATA_WIDTH-1:0] w_s0, w_s1, w_s2, w_s3, w_s4;
    logic [DATA_WIDTH-1:0] w_v5, w_v3, w_h5, w_h3, w_centre, w_borderVal;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_border5, w_border3;

    logic [DATA_WIDTH-1:0] r_oPixel;
    logic                  r_oValid, r_oSof, r_oEof;

    // Handshake, advance/emit decode and next-state; a sof accepted anywhere restarts the frame
    always_comb begin
        w_nextState = r_state;
        w_advance   = 1'b0;
        w_emit      = 1'b0;
        w_ready     = (r_state != ST_FLUSH);
        w_accept    = bus.i_valid & w_ready;
        w_restart   = w_accept & bus.i_sof;
        w_adv       = w_restart ? '0 : r_advCnt;
        if (w_restart) begin
            w_advance   = 1'b1;
            w_nextState = ST_FILL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nextState = ST_IDLE;
                end
                ST_FILL: begin
                    if (w_accept) begin
                        w_advance = 1'b1;
                        if (w_adv == FILL_LAST) w_nextState = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        w_advance = 1'b1;
                        w_emit    = 1'b1;
                        if (w_adv == RUN_LAST) w_nextState = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    w_advance = 1'b1;
                    w_emit    = 1'b1;
                    if (w_adv == FLUSH_LAST) w_nextState = ST_IDLE;
                end
                default: w_nextState = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    // Advance counter, write column, centre row/col and the per-frame mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_advCnt <= '0;
            r_wrCol  <= '0;
            r_cRow   <= '0;
            r_cCol   <= '0;
            r_mode   <= MODE_BYPASS;
        end else if (w_advance) begin
            r_advCnt <= w_adv + 1'b1;
            r_wrCol  <= (w_wrCol == COL_LAST) ? '0 : w_wrCol + 1'b1;
            if (w_restart) begin
                r_mode <= mode_t'(bus.i_mode);
                r_cRow <= '0;
                r_cCol <= '0;
            end else if (w_emit) begin
                if (r_cCol == COL_LAST) begin
                    r_cCol <= '0;
                    r_cRow <= r_cRow + 1'b1;
                end else begin
                    r_cCol <= r_cCol + 1'b1;
                end
            end
        end
    end

    assign w_wrCol = w_restart ? '0 : r_wrCol;
    assign w_s0    = (r_state == ST_FLUSH) ? '0 : bus.i_pixel;
    assign w_s1    = r_lb[0][w_wrCol];
    assign w_s2    = r_lb[1][w_wrCol];
    assign w_s3    = r_lb[2][w_wrCol];
    assign w_s4    = r_lb[3][w_wrCol];
    assign w_v5    = kern5(w_s0, w_s1, w_s2, w_s3, w_s4);
    assign w_v3    = kern3(w_s1, w_s2, w_s3);
    assign w_h5    = kern5(w_v5, r_h5[0], r_h5[1], r_h5[2], r_h5[3]);
    assign w_h3    = kern3(r_h3[0], r_h3[1], r_h3[2]);
    assign w_centre = r_ctr[1];

    // Line buffers cascade one row older per buffer at the current column; contents need no reset
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_lb[0][w_wrCol] <= w_s0;
            r_lb[1][w_wrCol] <= w_s1;
            r_lb[2][w_wrCol] <= w_s2;
            r_lb[3][w_wrCol] <= w_s3;
        end
    end

    // Horizontal histories of vertical results and the centre-pixel delay line
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_h5[0]  <= w_v5;
            r_h5[1]  <= r_h5[0];
            r_h5[2]  <= r_h5[1];
            r_h5[3]  <= r_h5[2];
            r_h3[0]  <= w_v3;
            r_h3[1]  <= r_h3[0];
            r_h3[2]  <= r_h3[1];
            r_ctr[0] <= w_s2;
            r_ctr[1] <= r_ctr[0];
        end
    end

    // Border classification around the centre and selection of the emitted value
    always_comb begin
        w_border5   = (r_cRow < ROW_TWO) | (r_cRow > ROW_HI5) |
                      (r_cCol < COL_TWO) | (r_cCol > COL_HI5);
        w_border3   = (r_cRow == '0) | (r_cRow == ROW_LAST) |
                      (r_cCol == '0) | (r_cCol == COL_LAST);
        w_borderVal = (BORDER_MODE != 0) ? w_centre : '0;
        case (r_mode)
            MODE_GAUSS5: w_result = w_border5 ? w_borderVal : w_h5;
            MODE_GAUSS3: w_result = w_border3 ? w_borderVal : w_h3;
            default:     w_result = w_centre;
        endcase
    end

    // Registered output stage; o_sof/o_eof flag the first and last centre of the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oPixel <= '0;
            r_oValid <= 1'b0;
            r_oSof   <= 1'b0;
            r_oEof   <= 1'b0;
        end else begin
            r_oValid <= w_emit;
            r_oSof   <= w_emit & (r_cRow == '0) & (r_cCol == '0);
            r_oEof   <= w_emit & (r_cRow == ROW_LAST) & (r_cCol == COL_LAST);
            if (w_emit) r_oPixel <= w_result;
        end
    end

    assign bus.i_ready = w_ready;
    assign bus.o_pixel = r_oPixel;
    assign bus.o_valid = r_oValid;
    assign bus.o_sof   = r_oSof;
    assign bus.o_eof   = r_oEof;
endmodule
